// File: rtl/instr_asm_pkg.sv
// Shared encodings for the instruction assembler: format codes, RV32I opcodes, defaults.
package instr_asm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_ISH = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam int unsigned ASM_ADDR_STEP = 4;

    // Typical opcode for a format; handy for sequencers building programs.
    function automatic logic [6:0] fmt_opcode(input fmt_e f);
        case (f)
            FMT_R:          return OP_REG;
            FMT_I, FMT_ISH: return OP_IMM;
            FMT_S:          return OP_STORE;
            FMT_B:          return OP_BRANCH;
            FMT_U:          return OP_LUI;
            FMT_J:          return OP_JAL;
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Request/response bus of the instruction assembler; master drives requests, slave is the assembler.
interface instr_assembler_if
    import instr_asm_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    fmt_e              fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [19:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields plus scrambled-field immediate -> 32-bit RV32I word.
module instr_pack
    import instr_asm_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [19:0] imm_i,
    output logic [31:0] instr_o
);
    always_comb begin
        instr_o = '0;
        case (fmt_i)
            FMT_R:   instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I:   instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_ISH: instr_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S:   instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            // B imm is {b12, b11, b10:5, b4:1}; J imm is {j20, j19:12, j11, j10:1}
            FMT_B:   instr_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                                imm_i[3:0], imm_i[10], opcode_i};
            FMT_U:   instr_o = {imm_i[19:0], rd_i, opcode_i};
            FMT_J:   instr_o = {imm_i[19], imm_i[9:0], imm_i[10], imm_i[18:11], rd_i, opcode_i};
            default: instr_o = '0;
        endcase
    end
endmodule

// File: rtl/instr_assembler.sv
// Packs instruction fields into RV32I words, buffers them in a 2-entry FIFO, tags each with an address.
// Optional build macro ROUNDTRIP_CHECK_EN adds a re-extraction check and sticky rt_mismatch output.
module instr_assembler
    import instr_asm_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       ADDR_STEP = ASM_ADDR_STEP
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    instr_assembler_if.slave   bus,
    output logic               err_illegal
`ifdef ROUNDTRIP_CHECK_EN
    ,
    output logic               rt_mismatch
`endif
);
    logic [31:0]       packed_w;
    logic [31:0]       mem_q [2];
    logic [31:0]       mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              accept, push, pop;

    instr_pack u_pack (
        .fmt_i    (bus.fmt),
        .opcode_i (bus.opcode),
        .rd_i     (bus.rd),
        .rs1_i    (bus.rs1),
        .rs2_i    (bus.rs2),
        .funct3_i (bus.funct3),
        .funct7_i (bus.funct7),
        .imm_i    (bus.imm),
        .instr_o  (packed_w)
    );

    assign bus.in_ready  = (count_q != 2'd2) && !clr;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_instr = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign bus.out_addr  = addr_q;
    assign err_illegal   = err_q;

    // Illegal formats complete the handshake but never enter the FIFO.
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && (bus.fmt != FMT_ILL);
    assign pop    = bus.out_valid && bus.out_ready && !clr;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        if (clr) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
            addr_d   = BASE_ADDR;
            err_d    = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = packed_w;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
                addr_d   = addr_q + ADDR_W'(ADDR_STEP);
            end
            if (accept && (bus.fmt == FMT_ILL)) begin
                err_d = 1'b1;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

`ifdef ROUNDTRIP_CHECK_EN
    logic [19:0] ext_imm, want_imm;
    logic        rt_q, rt_d;

    always_comb begin
        ext_imm  = '0;
        want_imm = '0;
        case (bus.fmt)
            FMT_ISH: begin
                ext_imm  = 20'(packed_w[24:20]);
                want_imm = 20'(bus.imm[4:0]);
            end
            FMT_I: begin
                ext_imm  = 20'(packed_w[31:20]);
                want_imm = 20'(bus.imm[11:0]);
            end
            FMT_S: begin
                ext_imm  = 20'({packed_w[31:25], packed_w[11:7]});
                want_imm = 20'(bus.imm[11:0]);
            end
            FMT_B: begin
                ext_imm  = 20'({packed_w[31], packed_w[7], packed_w[30:25], packed_w[11:8]});
                want_imm = 20'(bus.imm[11:0]);
            end
            FMT_U: begin
                ext_imm  = packed_w[31:12];
                want_imm = bus.imm;
            end
            FMT_J: begin
                ext_imm  = {packed_w[31], packed_w[19:12], packed_w[20], packed_w[30:21]};
                want_imm = bus.imm;
            end
            default: begin
                ext_imm  = '0;
                want_imm = '0;
            end
        endcase
        rt_d = clr ? 1'b0 : (rt_q || (push && (ext_imm != want_imm)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rt_q <= 1'b0;
        end else begin
            rt_q <= rt_d;
        end
    end

    assign rt_mismatch = rt_q;
`endif

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: packing table, back-to-back, backpressure, illegal/clr, async reset.
module tb_instr_assembler;
    import instr_asm_pkg::*;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [19:0] imm;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 9;

    logic clk = 1'b0;
    logic rstn;
    logic clr;
    logic err_illegal;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_addr;
    vec_t vecs [NV];

    instr_assembler_if #(.ADDR_W(32)) bus ();

`ifdef ROUNDTRIP_CHECK_EN
    logic rt_mismatch;
`endif

    instr_assembler #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_0000),
        .ADDR_STEP (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .bus         (bus),
        .err_illegal (err_illegal)
`ifdef ROUNDTRIP_CHECK_EN
        ,
        .rt_mismatch (rt_mismatch)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input vec_t v);
        bus.fmt      = fmt_e'(v.fmt);
        bus.opcode   = v.op;
        bus.rd       = v.rd;
        bus.rs1      = v.rs1;
        bus.rs2      = v.rs2;
        bus.funct3   = v.f3;
        bus.funct7   = v.f7;
        bus.imm      = v.imm;
        bus.in_valid = 1'b1;
    endtask

    initial begin
        //            fmt   op     rd  rs1 rs2 f3    f7     imm        expected
        vecs[0] = '{3'd1, 7'h13, 1,  0,  0,  3'd0, 7'h00, 20'h00005, 32'h0050_0093}; // addi x1,x0,5
        vecs[1] = '{3'd3, 7'h23, 0,  1,  2,  3'd2, 7'h00, 20'h00008, 32'h0020_A423}; // sw x2,8(x1)
        vecs[2] = '{3'd4, 7'h63, 0,  0,  0,  3'd0, 7'h00, 20'h00FFE, 32'hFE00_0EE3}; // beq x0,x0,-4
        vecs[3] = '{3'd5, 7'h37, 5,  0,  0,  3'd0, 7'h00, 20'h12345, 32'h1234_52B7}; // lui x5,0x12345
        vecs[4] = '{3'd6, 7'h6F, 1,  0,  0,  3'd0, 7'h00, 20'h00004, 32'h0080_00EF}; // jal x1,+8
        vecs[5] = '{3'd0, 7'h33, 3,  1,  2,  3'd0, 7'h00, 20'hFFFFF, 32'h0020_81B3}; // add, imm ignored
        vecs[6] = '{3'd2, 7'h13, 4,  4,  0,  3'd5, 7'h20, 20'hFFFE3, 32'h4032_5213}; // srai, upper imm ignored
        vecs[7] = '{3'd1, 7'h13, 1,  0,  0,  3'd0, 7'h00, 20'hAB005, 32'h0050_0093}; // addi, upper imm ignored
        vecs[8] = '{3'd6, 7'h6F, 0,  0,  0,  3'd0, 7'h00, 20'hFFFFF, 32'hFFFF_F06F}; // jal all-ones imm

        rstn = 1'b0;
        clr  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.fmt = FMT_R; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_instr", bus.out_instr, 32'h0);
        chk("rst out_addr", bus.out_addr, 32'h0);
        chk("rst err_illegal", 32'(err_illegal), 32'd0);
        rstn = 1'b1;
        step();

        // Single-word table: one cycle latency, address advances per pop.
        exp_addr = 32'h0;
        for (int i = 0; i < NV; i++) begin
            send(vecs[i]);
            #1 chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d out_instr", i), bus.out_instr, vecs[i].exp);
            chk($sformatf("vec%0d out_addr", i), bus.out_addr, exp_addr);
            step();
            exp_addr += 32'd4;
            chk($sformatf("vec%0d drained", i), 32'(bus.out_valid), 32'd0);
        end

        // S then B back to back with a draining consumer.
        clr = 1'b1;
        step();
        clr = 1'b0;
        send(vecs[1]);
        step();
        chk("b2b sw instr", bus.out_instr, 32'h0020_A423);
        chk("b2b sw addr", bus.out_addr, 32'h0);
        send(vecs[2]);
        #1 chk("b2b in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("b2b beq valid", 32'(bus.out_valid), 32'd1);
        chk("b2b beq instr", bus.out_instr, 32'hFE00_0EE3);
        chk("b2b beq addr", bus.out_addr, 32'h4);
        step();
        chk("b2b drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: third push stalls at count=2, order and addresses preserved.
        clr = 1'b1;
        step();
        clr = 1'b0;
        bus.out_ready = 1'b0;
        send(vecs[3]);
        step();
        send(vecs[4]);
        #1 chk("bp in_ready c1", 32'(bus.in_ready), 32'd1);
        step();
        send(vecs[5]);
        #1 chk("bp in_ready c2", 32'(bus.in_ready), 32'd0);
        step();
        chk("bp stall in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp head instr", bus.out_instr, vecs[3].exp);
        chk("bp head addr", bus.out_addr, 32'h0);
        bus.out_ready = 1'b1;
        step();
        chk("bp w2 instr", bus.out_instr, vecs[4].exp);
        chk("bp w2 addr", bus.out_addr, 32'h4);
        chk("bp w3 ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp w3 valid", 32'(bus.out_valid), 32'd1);
        chk("bp w3 instr", bus.out_instr, vecs[5].exp);
        chk("bp w3 addr", bus.out_addr, 32'h8);
        step();
        chk("bp drained", 32'(bus.out_valid), 32'd0);
        chk("bp final addr", bus.out_addr, 32'hC);

        // Illegal format: accepted, flagged, never emitted; clr recovers.
        send(vecs[0]);
        bus.fmt = FMT_ILL;
        #1 chk("ill in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("ill err set", 32'(err_illegal), 32'd1);
        chk("ill no output", 32'(bus.out_valid), 32'd0);
        step();
        chk("ill err sticky", 32'(err_illegal), 32'd1);
        chk("ill addr held", bus.out_addr, 32'hC);
        clr = 1'b1;
        send(vecs[0]);
        #1 chk("clr in_ready", 32'(bus.in_ready), 32'd0);
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr err", 32'(err_illegal), 32'd0);
        chk("clr addr", bus.out_addr, 32'h0);
        chk("clr drop push", 32'(bus.out_valid), 32'd0);

        // Async reset with two words queued.
        send(vecs[0]);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("pre-rst addr", bus.out_addr, 32'h4);
        bus.out_ready = 1'b0;
        send(vecs[1]);
        step();
        send(vecs[2]);
        step();
        bus.in_valid = 1'b0;
        #1 chk("pre-rst full", 32'(bus.in_ready), 32'd0);
        rstn = 1'b0;
        #1;
        chk("arst out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst out_instr", bus.out_instr, 32'h0);
        chk("arst out_addr", bus.out_addr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        send(vecs[3]);
        step();
        bus.in_valid = 1'b0;
        chk("post-rst instr", bus.out_instr, vecs[3].exp);
        chk("post-rst addr", bus.out_addr, 32'h0);
        step();
        chk("post-rst drained", 32'(bus.out_valid), 32'd0);
`ifdef ROUNDTRIP_CHECK_EN
        chk("rt_mismatch", 32'(rt_mismatch), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the immediate-extraction stage: takes decoded instruction fields and scrambled-field immediates, and packs them into 32-bit RV32I instruction words.
- Packed words are buffered in a 2-entry FIFO and emitted with a valid/ready handshake, each tagged with an incrementing word address.
- Feeds the instruction-memory loader and the self-test program generator; sits between the test sequencer and IMEM write port.

Parameters:
- ADDR_W, 32, width of out_addr
- BASE_ADDR, 32'h0000_0000, address tagged on first emitted word after reset/clr
- ADDR_STEP, 4, address increment per emitted word

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: FIFO, address counter, err_illegal
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- fmt  in  3  format: R=0, I=1, ISH=2, S=3, B=4, U=5, J=6; 7 illegal
- opcode  in  7  instr[6:0]
- rd  in  5  instr[11:7] (R/I/ISH/U/J)
- rs1  in  5  instr[19:15] (R/I/ISH/S/B)
- rs2  in  5  instr[24:20] (R/S/B)
- funct3  in  3  instr[14:12] (R/I/ISH/S/B)
- funct7  in  7  instr[31:25] (R/ISH)
- imm  in  20  field immediate, low bits used: ISH [4:0]; I/S/B [11:0]; U/J [19:0]
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts
- out_instr  out  32  packed word (FIFO head)
- out_addr  out  ADDR_W  address of head word
- err_illegal  out  1  sticky: illegal fmt seen

Behaviour:
- Reset: out_valid=0, in_ready=1, out_instr=0, out_addr=BASE_ADDR, err_illegal=0, FIFO count=0.
- Packing (combinational on inputs, registered into FIFO on accept):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - ISH: {funct7, imm[4:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B (imm = {b12, b11, b10:5, b4:1}): {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}
  - U: {imm[19:0], rd, opcode}
  - J (imm = {j20, j19:12, j11, j10:1}): {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode}
  - Unused imm bits are ignored.
- Latency: accept in cycle N gives out_valid=1 in N+1 (empty FIFO). No combinational in-to-out path.
- FIFO: 2 entries; count 0..2; wr/rd pointers wrap mod 2.
  - in_ready = (count<2) & ~clr.
  - Simultaneous push and pop at count=2 is not allowed (in_ready=0).
  - At count=1, push+pop keeps count=1.
- Address: out_addr increments by ADDR_STEP on each out handshake and wraps modulo 2^ADDR_W. Address is assigned at pop, not push.
- Illegal fmt (7): request is accepted (in_ready honoured) but not enqueued; err_illegal set, held until clr/reset.
- clr: in the cycle after clr=1, count=0, out_valid=0, out_addr=BASE_ADDR, err_illegal=0. Handshakes in a clr cycle are dropped.
- rstn low mid-transfer: everything returns to reset values immediately; no partial word survives.

Optional Feature:
- ROUNDTRIP_CHECK_EN
- Defined:
  - On each push, re-extract shamt/i/s/b/u/j immediates from the packed word and compare the format-relevant one against the masked imm.
  - On mismatch, set sticky output rt_mismatch (1 bit, cleared by clr/rstn).
- Undefined: rt_mismatch port and compare logic are absent.

Decomposition:
- Package instr_asm_pkg: fmt encodings (FMT_R..FMT_J, FMT_ILL), RV32I opcode constants (OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_LUI=7'h37, OP_JAL=7'h6F, OP_REG=7'h33), ADDR_STEP default.
- Sub-module instr_pack: purely combinational fmt/field → 32-bit word, reused by the roundtrip checker's testbench.

Test Plan:
- I addi x1,x0,5: fmt=1, op=13, rd=1, rs1=0, f3=0, imm=005 → out_instr=0x00500093, out_addr=0, out_valid one cycle after accept.
- S then B, back-to-back:
  - sw x2,8(x1) (fmt=3, rs1=1, rs2=2, f3=2, imm=008) → 0x0020A423 at addr 0.
  - beq x0,x0,-4 (fmt=4, imm=FFE) → 0xFE000EE3 at addr 4.
- U/J:
  - lui x5,0x12345 → 0x123452B7.
  - jal x1,+8 (fmt=6, imm=00004) → 0x008000EF.
- Backpressure: out_ready=0, push 3 words → third stalls (in_ready=0 at count=2); release out_ready → words emitted in order at addrs 0, 4, 8, no loss.
- fmt=7 accepted → err_illegal=1, nothing emitted. Then clr → err_illegal=0, out_addr=BASE_ADDR.
- rstn asserted with 2 words queued → out_valid=0 immediately. After release, next word tagged BASE_ADDR.
